// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: ID-side bundle in, EX-side bundle out, plus stall/bubble/redirect handshake
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    logic              id_valid;
    logic              id_alusrca;
    logic [1:0]        id_alusrcb;
    logic [1:0]        id_memtoreg;
    logic              id_regwrite;
    logic              id_dmemread;
    logic              id_dmemwrite;
    logic [1:0]        id_aluop;
    logic [1:0]        id_regdst;
    logic [5:0]        id_funct;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic [RA_W-1:0]   id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic              flush;
    logic              ex_hold;
    logic              ex_valid;
    logic              ex_alusrca;
    logic [1:0]        ex_alusrcb;
    logic [1:0]        ex_memtoreg;
    logic              ex_regwrite;
    logic              ex_dmemread;
    logic              ex_dmemwrite;
    logic [1:0]        ex_aluop;
    logic [1:0]        ex_regdst;
    logic [5:0]        ex_funct;
    logic [RA_W-1:0]   ex_rs;
    logic [RA_W-1:0]   ex_rt;
    logic [RA_W-1:0]   ex_rd;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic [RA_W-1:0]   ex_dst;
    logic              stall;
    logic              bubble;

    modport master (
        output id_valid, id_alusrca, id_alusrcb, id_memtoreg, id_regwrite, id_dmemread,
               id_dmemwrite, id_aluop, id_regdst, id_funct, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm, id_pc4, flush, ex_hold,
        input  ex_valid, ex_alusrca, ex_alusrcb, ex_memtoreg, ex_regwrite, ex_dmemread,
               ex_dmemwrite, ex_aluop, ex_regdst, ex_funct, ex_rs, ex_rt, ex_rd,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_dst, stall, bubble
    );

    modport slave (
        input  id_valid, id_alusrca, id_alusrcb, id_memtoreg, id_regwrite, id_dmemread,
               id_dmemwrite, id_aluop, id_regdst, id_funct, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm, id_pc4, flush, ex_hold,
        output ex_valid, ex_alusrca, ex_alusrcb, ex_memtoreg, ex_regwrite, ex_dmemread,
               ex_dmemwrite, ex_aluop, ex_regdst, ex_funct, ex_rs, ex_rt, ex_rd,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_dst, stall, bubble
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use detection; ID_EX_PERF_CNT_EN adds bubble/hold counters
module id_ex_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int RA_W     = 5,
    parameter int LINK_REG = 31
) (
    input  logic clk,
    input  logic rst_n,
    id_ex_stage_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_hold_cnt
`endif
);
    localparam logic [RA_W-1:0] LINK = RA_W'(LINK_REG);

    logic            luh;
    logic            do_hold;
    logic            do_bubble;
    logic [RA_W-1:0] dst_sel;

    // hazard detection, edge-action select and destination resolution
    always_comb begin
        luh = bus.ex_valid && bus.ex_dmemread && (bus.ex_dst != '0) && bus.id_valid &&
              ((bus.ex_dst == bus.id_rs) || (bus.ex_dst == bus.id_rt));
        do_hold = !bus.flush && bus.ex_hold;
        do_bubble = bus.flush || (!bus.ex_hold && luh);
        bus.stall = !bus.flush && (luh || bus.ex_hold);
        dst_sel = bus.id_regdst == 2'd0 ? bus.id_rd :
                  bus.id_regdst == 2'd1 ? bus.id_rt :
                  bus.id_regdst == 2'd2 ? LINK : '0;
    end

    // control bits: cleared on bubble, frozen on hold, write-enables gated by id_valid on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_regwrite  <= 1'b0;
            bus.ex_dmemread  <= 1'b0;
            bus.ex_dmemwrite <= 1'b0;
            bus.bubble       <= 1'b0;
        end else if (do_bubble) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_regwrite  <= 1'b0;
            bus.ex_dmemread  <= 1'b0;
            bus.ex_dmemwrite <= 1'b0;
            bus.bubble       <= 1'b1;
        end else if (do_hold) begin
            bus.bubble       <= 1'b0;
        end else begin
            bus.ex_valid     <= bus.id_valid;
            bus.ex_regwrite  <= bus.id_valid && bus.id_regwrite;
            bus.ex_dmemread  <= bus.id_valid && bus.id_dmemread;
            bus.ex_dmemwrite <= bus.id_valid && bus.id_dmemwrite;
            bus.bubble       <= 1'b0;
        end
    end

    // datapath fields only move on a capture edge; bubbles and holds leave them as they were
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_alusrca  <= 1'b0;
            bus.ex_alusrcb  <= '0;
            bus.ex_memtoreg <= '0;
            bus.ex_aluop    <= '0;
            bus.ex_regdst   <= '0;
            bus.ex_funct    <= '0;
            bus.ex_rs       <= '0;
            bus.ex_rt       <= '0;
            bus.ex_rd       <= '0;
            bus.ex_rs_data  <= '0;
            bus.ex_rt_data  <= '0;
            bus.ex_imm      <= '0;
            bus.ex_pc4      <= '0;
            bus.ex_dst      <= '0;
        end else if (!do_bubble && !do_hold) begin
            bus.ex_alusrca  <= bus.id_alusrca;
            bus.ex_alusrcb  <= bus.id_alusrcb;
            bus.ex_memtoreg <= bus.id_memtoreg;
            bus.ex_aluop    <= bus.id_aluop;
            bus.ex_regdst   <= bus.id_regdst;
            bus.ex_funct    <= bus.id_funct;
            bus.ex_rs       <= bus.id_rs;
            bus.ex_rt       <= bus.id_rt;
            bus.ex_rd       <= bus.id_rd;
            bus.ex_rs_data  <= bus.id_rs_data;
            bus.ex_rt_data  <= bus.id_rt_data;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_pc4      <= bus.id_pc4;
            bus.ex_dst      <= dst_sel;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // free-running wrap-around counters of bubble edges and hold edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt <= '0;
            perf_hold_cnt   <= '0;
        end else begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'(do_bubble);
            perf_hold_cnt   <= perf_hold_cnt + 32'(do_hold);
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vectors for reset, load-use, $0 load, flush/hold, hold, JAL and invalid capture
module tb_id_ex_stage_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    id_ex_stage_reg_if #(.DATA_W(32), .RA_W(5)) b ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_hold_cnt;
    id_ex_stage_reg dut (.clk(clk), .rst_n(rst_n), .bus(b.slave),
                         .perf_bubble_cnt(perf_bubble_cnt), .perf_hold_cnt(perf_hold_cnt));
`else
    id_ex_stage_reg dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic ld, input logic rw, input logic [1:0] dm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d);
        b.id_valid     = v;
        b.id_dmemread  = ld;
        b.id_regwrite  = rw;
        b.id_regdst    = dm;
        b.id_rs        = rs;
        b.id_rt        = rt;
        b.id_rd        = rd;
        b.id_rs_data   = d;
        b.id_rt_data   = ~d;
        b.id_imm       = d ^ 32'h0000_5a5a;
        b.id_pc4       = d + 32'd4;
        b.id_alusrca   = 1'b1;
        b.id_alusrcb   = 2'd2;
        b.id_memtoreg  = ld ? 2'd1 : 2'd0;
        b.id_dmemwrite = 1'b0;
        b.id_aluop     = 2'd2;
        b.id_funct     = 6'h20;
    endtask

    initial begin
        rst_n = 1'b0;
        b.flush = 1'b0;
        b.ex_hold = 1'b0;
        set_id(1'b1, 1'b1, 1'b1, 2'd1, 5'd3, 5'd4, 5'd5, 32'h1111_1111);
        b.id_dmemwrite = 1'b1;
        b.id_memtoreg = 2'd2;
        b.id_funct = 6'h2a;
        b.id_alusrcb = 2'd3;
        tick();
        tick();
        check("rst_valid", 32'(b.ex_valid), 32'd0);
        check("rst_rsdata", b.ex_rs_data, 32'd0);
        check("rst_bubble", 32'(b.bubble), 32'd0);
        rst_n = 1'b1;
        tick();
        check("cap_valid", 32'(b.ex_valid), 32'd1);
        check("cap_dst_rt", 32'(b.ex_dst), 32'd4);
        check("cap_pc4", b.ex_pc4, 32'h1111_1115);
        check("cap_funct", 32'(b.ex_funct), 32'h2a);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(b.ex_valid), 32'd0);
        check("async_dst", 32'(b.ex_dst), 32'd0);
        check("async_rsdata", b.ex_rs_data, 32'd0);
        check("async_wr", 32'(b.ex_dmemwrite), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_rsdata", b.ex_rs_data, 32'h1111_1111);
        check("rel_imm", b.ex_imm, 32'h1111_4b4b);
        check("rel_luh_stall", 32'(b.stall), 32'd1);

        set_id(1'b1, 1'b1, 1'b1, 2'd1, 5'd2, 5'd8, 5'd0, 32'h0000_1000);
        #1 check("lw_nostall", 32'(b.stall), 32'd0);
        tick();
        check("lw_dst", 32'(b.ex_dst), 32'd8);
        check("lw_rd", 32'(b.ex_dmemread), 32'd1);
        set_id(1'b1, 1'b0, 1'b1, 2'd0, 5'd8, 5'd9, 5'd10, 32'h0000_2000);
        #1 check("lu_stall", 32'(b.stall), 32'd1);
        tick();
        check("lu_valid", 32'(b.ex_valid), 32'd0);
        check("lu_bubble", 32'(b.bubble), 32'd1);
        check("lu_rw", 32'(b.ex_regwrite), 32'd0);
        check("lu_stall_drop", 32'(b.stall), 32'd0);
        tick();
        check("add_valid", 32'(b.ex_valid), 32'd1);
        check("add_dst", 32'(b.ex_dst), 32'd10);
        check("add_bubble", 32'(b.bubble), 32'd0);
        check("add_rsdata", b.ex_rs_data, 32'h0000_2000);

        set_id(1'b1, 1'b1, 1'b1, 2'd1, 5'd1, 5'd0, 5'd7, 32'h0000_3000);
        tick();
        check("z_dst", 32'(b.ex_dst), 32'd0);
        set_id(1'b1, 1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 5'd11, 32'h0000_4000);
        #1 check("z_stall", 32'(b.stall), 32'd0);
        tick();
        check("z_bubble", 32'(b.bubble), 32'd0);
        check("z_dst2", 32'(b.ex_dst), 32'd11);

        b.flush = 1'b1;
        b.ex_hold = 1'b1;
        #1 check("fh_stall", 32'(b.stall), 32'd0);
        tick();
        check("fh_valid", 32'(b.ex_valid), 32'd0);
        check("fh_rw", 32'(b.ex_regwrite), 32'd0);
        check("fh_bubble", 32'(b.bubble), 32'd1);
        b.flush = 1'b0;
        b.ex_hold = 1'b0;

        set_id(1'b1, 1'b0, 1'b1, 2'd0, 5'd1, 5'd2, 5'd12, 32'hAAAA_0000);
        tick();
        check("h0_dst", 32'(b.ex_dst), 32'd12);
        b.ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 1'b0, 1'b1, 2'd0, 5'd3, 5'd4, 5'(13 + i), 32'hB000_0000 + 32'(i));
            #1 check("h_stall", 32'(b.stall), 32'd1);
            tick();
            check("h_dst", 32'(b.ex_dst), 32'd12);
            check("h_rsdata", b.ex_rs_data, 32'hAAAA_0000);
            check("h_bubble", 32'(b.bubble), 32'd0);
        end
        b.ex_hold = 1'b0;
        tick();
        check("h_cap_dst", 32'(b.ex_dst), 32'd15);
        check("h_cap_data", b.ex_rs_data, 32'hB000_0002);
`ifdef ID_EX_PERF_CNT_EN
        check("perf_bubble", perf_bubble_cnt, 32'd2);
        check("perf_hold", perf_hold_cnt, 32'd3);
`endif

        set_id(1'b1, 1'b0, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 32'h0040_0000);
        b.id_memtoreg = 2'd2;
        tick();
        check("jal_dst", 32'(b.ex_dst), 32'd31);
        check("jal_m2r", 32'(b.ex_memtoreg), 32'd2);
        check("jal_rw", 32'(b.ex_regwrite), 32'd1);

        set_id(1'b1, 1'b0, 1'b1, 2'd3, 5'd6, 5'd7, 5'd9, 32'h0000_5000);
        tick();
        check("rd3_dst", 32'(b.ex_dst), 32'd0);

        set_id(1'b0, 1'b1, 1'b1, 2'd0, 5'd6, 5'd7, 5'd9, 32'h0000_6000);
        b.id_dmemwrite = 1'b1;
        b.id_funct = 6'h08;
        tick();
        check("inv_valid", 32'(b.ex_valid), 32'd0);
        check("inv_rw", 32'(b.ex_regwrite), 32'd0);
        check("inv_mr", 32'(b.ex_dmemread), 32'd0);
        check("inv_mw", 32'(b.ex_dmemwrite), 32'd0);
        check("inv_funct", 32'(b.ex_funct), 32'h08);
        check("inv_bubble", 32'(b.bubble), 32'd0);

        set_id(1'b1, 1'b1, 1'b1, 2'd1, 5'd1, 5'd8, 5'd0, 32'h0000_7000);
        tick();
        set_id(1'b1, 1'b0, 1'b1, 2'd0, 5'd2, 5'd8, 5'd3, 32'h0000_8000);
        #1 check("mr_stall", 32'(b.stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_stall_rst", 32'(b.stall), 32'd0);
        check("mr_valid", 32'(b.ex_valid), 32'd0);
        check("mr_dst", 32'(b.ex_dst), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        check("mr_perf", perf_bubble_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("mr_recap", 32'(b.ex_dst), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
